// File: rtl/dbg_trace_pkg.sv
// dbg_trace_pkg: shared types and constants for the FSM state trace block.
//   dbg_chw()          channel-id field width for a given channel count
//   dbg_entry_t        entry layout {chan, state, ts} at the default widths
//   DBG_TRACE_POST_DIV post-trigger capture is DEPTH / DBG_TRACE_POST_DIV entries
//   fz_state_e         freeze controller states
package dbg_trace_pkg;

  localparam int DBG_TRACE_POST_DIV = 2;

  // A single channel still needs a 1-bit id field so the entry layout is uniform.
  function automatic int dbg_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DBG_NCH_DEF  = 5;
  localparam int DBG_ST_W_DEF = 5;
  localparam int DBG_TS_W_DEF = 16;
  localparam int DBG_CHW_DEF  = dbg_chw(DBG_NCH_DEF);

  typedef struct packed {
    logic [DBG_CHW_DEF-1:0]  chan;
    logic [DBG_ST_W_DEF-1:0] state;
    logic [DBG_TS_W_DEF-1:0] ts;
  } dbg_entry_t;

  typedef enum logic [1:0] {
    FZ_IDLE   = 2'd0,
    FZ_ARMED  = 2'd1,
    FZ_FROZEN = 2'd2
  } fz_state_e;

endpackage

// File: rtl/dbg_fsm_trace_if.sv
// dbg_fsm_trace_if: valid/ready readout port of the trace FIFO.
//   rd_valid  entry available (source -> sink)
//   rd_ready  sink accepts head entry (sink -> source)
//   rd_data   head entry {chan, state, ts}, DW bits
interface dbg_fsm_trace_if #(
  parameter int DW = 24
);
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/dbg_trace_fifo.sv
// dbg_trace_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst   clock, synchronous active-high reset
//   clr_i      synchronous flush (priority over push/pop)
//   push_i     write din_i (ignored when full)
//   din_i      write data
//   pop_i      drop head entry (ignored when empty)
//   dout_o     head entry, zero when empty
//   full_o     DEPTH entries held
//   empty_o    no entries held
//   fill_o     occupancy 0..DEPTH
module dbg_trace_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Hide stale storage so the read port reads zero when nothing is queued.
  assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/dbg_fsm_trace.sv
// dbg_fsm_trace: timestamped change log of NCH FSM state buses.
//   clk, rst   clock, synchronous active-high reset
//   fsm_in     packed states, channel i at [i*ST_W +: ST_W]
//   trace_en   enable change capture (timestamp always runs)
//   clr        flush FIFO, overflow, freeze, timestamp and shadows
//   trig       fault trigger (post-trigger freeze build only)
//   rd         readout port (master): {chan, state, ts} entries
//   fill       FIFO occupancy
//   ovf        sticky: a change was held back by a full FIFO
//   frozen     capture stopped after the post-trigger window
// Build option: DBG_TRACE_FREEZE_EN enables the trig-driven freeze.
module dbg_fsm_trace
  import dbg_trace_pkg::*;
#(
  parameter int NCH   = 5,
  parameter int ST_W  = 5,
  parameter int TS_W  = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*ST_W-1:0]    fsm_in,
  input  logic                   trace_en,
  input  logic                   clr,
  input  logic                   trig,
  dbg_fsm_trace_if.master        rd,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   ovf,
  output logic                   frozen
);
  localparam int CHW = dbg_chw(NCH);
  localparam int DW  = CHW + ST_W + TS_W;

  logic [NCH-1:0][ST_W-1:0] st, sh_q;
  logic [NCH-1:0]           pend;
  logic [CHW-1:0]           sel;
  logic [ST_W-1:0]          st_sel;
  logic                     any_pend, want_push, push, full, empty;
  logic [TS_W-1:0]          ts_q;
  logic                     ovf_q;

  assign st = fsm_in;

  for (genvar i = 0; i < NCH; i++) begin : g_pend
    assign pend[i] = (st[i] != sh_q[i]);
  end

  // Fixed priority: scanning downward leaves the lowest pending index in sel.
  always_comb begin
    sel      = '0;
    st_sel   = '0;
    any_pend = 1'b0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (pend[i]) begin
        sel      = CHW'(i);
        st_sel   = st[i];
        any_pend = 1'b1;
      end
    end
  end

  // full is the registered occupancy, so a same-cycle pop never frees a slot.
  assign want_push = trace_en & any_pend & ~frozen;
  assign push      = want_push & ~full;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ts_q  <= '0;
      ovf_q <= 1'b0;
      sh_q  <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (want_push && full) ovf_q <= 1'b1;
      // Shadow only advances on a logged entry; blocked changes stay pending
      // and coalesce into whatever value is present when serviced.
      for (int i = 0; i < NCH; i++)
        if (push && sel == CHW'(i)) sh_q[i] <= st[i];
    end
  end

  dbg_trace_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .push_i  (push),
    .din_i   ({sel, st_sel, ts_q}),
    .pop_i   (rd.rd_ready),
    .dout_o  (rd.rd_data),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

  assign rd.rd_valid = ~empty;
  assign ovf         = ovf_q;

`ifdef DBG_TRACE_FREEZE_EN
  localparam int POST_N = DEPTH / DBG_TRACE_POST_DIV;
  localparam int PCW    = $clog2(POST_N + 1);

  fz_state_e      fz_q, fz_d;
  logic           trig_q;
  logic [PCW-1:0] post_q, post_d;

  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fz_q   <= FZ_IDLE;
      post_q <= '0;
    end else begin
      fz_q   <= fz_d;
      post_q <= post_d;
    end
  end

  // Pushes in the edge-detect cycle itself precede arming and are not counted.
  always_comb begin
    fz_d   = fz_q;
    post_d = post_q;
    case (fz_q)
      FZ_IDLE: begin
        if (trig && !trig_q) begin
          fz_d   = FZ_ARMED;
          post_d = '0;
        end
      end
      FZ_ARMED: begin
        if (push) begin
          if (post_q == PCW'(POST_N - 1)) fz_d = FZ_FROZEN;
          else                            post_d = post_q + 1'b1;
        end
      end
      FZ_FROZEN: fz_d = FZ_FROZEN;
      default:   fz_d = FZ_IDLE;
    endcase
  end

  assign frozen = (fz_q == FZ_FROZEN);
`else
  logic unused_trig;
  assign unused_trig = trig;
  assign frozen      = 1'b0;
`endif
endmodule

// File: tb/tb_dbg_fsm_trace.sv
module tb_dbg_fsm_trace;
  import dbg_trace_pkg::*;

  localparam int NCH   = 5;
  localparam int ST_W  = 5;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 24;

  logic                clk = 1'b0;
  logic                rst, trace_en, clr, trig;
  logic [NCH*ST_W-1:0] fsm_in;
  logic [2:0]          fill;
  logic                ovf, frozen;

  dbg_fsm_trace_if #(.DW(DW)) rd_if ();

  dbg_fsm_trace #(.NCH(NCH), .ST_W(ST_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fsm_in(fsm_in), .trace_en(trace_en), .clr(clr),
    .trig(trig), .rd(rd_if), .fill(fill), .ovf(ovf), .frozen(frozen)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cs(input int c, input int s);
    return {3'(c), 5'(s)};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  dbg_entry_t       m_q[$];
  logic [7:0]       dq[$];        // directed {chan,state} expectations
  logic [ST_W-1:0]  m_sh [NCH];
  logic [TS_W-1:0]  m_ts;
  bit               m_ovf, m_full, m_pop, m_push, m_trq;
  int               m_sel, m_fz, m_cnt;
  dbg_entry_t       e, e_drop;

  always @(posedge clk) begin
    if (rst || clr) begin
      m_q.delete();
      m_ts  = '0;
      m_ovf = 0;
      for (int i = 0; i < NCH; i++) m_sh[i] = '0;
      m_fz  = 0;
      m_cnt = 0;
      m_trq = rst ? 1'b0 : trig;
    end else begin
      m_sel = -1;
      for (int i = 0; i < NCH; i++)
        if (m_sel < 0 && fsm_in[i*ST_W +: ST_W] != m_sh[i]) m_sel = i;
      m_full = (m_q.size() == DEPTH);
      m_pop  = rd_if.rd_ready && (m_q.size() != 0);
      m_push = 0;
      if (trace_en && m_sel >= 0 && m_fz != 2) begin
        if (m_full) m_ovf = 1;
        else begin
          e.chan  = 3'(m_sel);
          e.state = fsm_in[m_sel*ST_W +: ST_W];
          e.ts    = m_ts;
          m_q.push_back(e);
          m_sh[m_sel] = e.state;
          m_push = 1;
        end
      end
      if (m_pop) e_drop = m_q.pop_front();
`ifdef DBG_TRACE_FREEZE_EN
      if (m_fz == 0 && trig && !m_trq) begin m_fz = 1; m_cnt = 0; end
      else if (m_fz == 1 && m_push) begin
        m_cnt++;
        if (m_cnt == DEPTH/2) m_fz = 2;
      end
      m_trq = trig;
`endif
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("fill", 32'(fill), 32'(m_q.size()));
    chk("rd_valid", 32'(rd_if.rd_valid), 32'(m_q.size() != 0));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("frozen", 32'(frozen), 32'(m_fz == 2));
    if (rd_if.rd_valid && rd_if.rd_ready) begin
      if (m_q.size() == 0) chk("pop_unexp", 32'(rd_if.rd_valid), 32'd0);
      else begin
        chk("pop_data", 32'(rd_if.rd_data), 32'(m_q[0]));
        if (dq.size() != 0) begin
          chk("pop_chst", 32'(rd_if.rd_data[DW-1:TS_W]), 32'(dq[0]));
          void'(dq.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int v);
    fsm_in[c*ST_W +: ST_W] = ST_W'(v);
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog act=timeout exp=finish");
    finish_run();
  end

  initial begin
    int exp_fill;
    rst = 1; clr = 0; trig = 0; trace_en = 1; fsm_in = '0; rd_if.rd_ready = 0;
    tick(3);
    chk("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    chk("rst_fill",  32'(fill), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_frz",   32'(frozen), 32'd0);
    chk("rst_data",  32'(rd_if.rd_data), 32'd0);

    // 1: single change, first entry one cycle after reset release
    rst = 0; set_ch(2, 3);
    tick();
    chk("t1_valid", 32'(rd_if.rd_valid), 32'd1);
    chk("t1_fill",  32'(fill), 32'd1);
    chk("t1_data",  32'(rd_if.rd_data), 32'h43_0000);
    dq.push_back(cs(2, 3));
    rd_if.rd_ready = 1; tick(); rd_if.rd_ready = 0;
    chk("t1_drain", 32'(fill), 32'd0);

    // 2: two channels change together -> consecutive entries
    set_ch(1, 5); set_ch(3, 7);
    tick(2);
    chk("t2_fill", 32'(fill), 32'd2);
    chk("t2_head", 32'(rd_if.rd_data[DW-1:TS_W]), 32'(cs(1, 5)));
    dq.push_back(cs(1, 5)); dq.push_back(cs(3, 7));
    rd_if.rd_ready = 1; tick(2); rd_if.rd_ready = 0;

    // trace_en low blocks capture; pop on empty is harmless
    trace_en = 0; set_ch(4, 2);
    tick(3);
    chk("ten_fill", 32'(fill), 32'd0);
    rd_if.rd_ready = 1; tick(); rd_if.rd_ready = 0;
    chk("empty_pop", 32'(fill), 32'd0);
    trace_en = 1;
    tick();
    chk("ten_on", 32'(rd_if.rd_data[DW-1:TS_W]), 32'(cs(4, 2)));
    dq.push_back(cs(4, 2));
    rd_if.rd_ready = 1; tick(); rd_if.rd_ready = 0;

    // 3: overflow with five pending channels
    set_ch(0, 1); set_ch(1, 6); set_ch(2, 4); set_ch(3, 8); set_ch(4, 9);
    tick(6);
    chk("t3_fill", 32'(fill), 32'd4);
    chk("t3_ovf",  32'(ovf), 32'd1);
    chk("t3_head", 32'(rd_if.rd_data[DW-1:TS_W]), 32'(cs(0, 1)));

    // 4: ch0 toggles while blocked -> only final value logged
    set_ch(0, 2); tick(); set_ch(0, 3); tick();
    dq.push_back(cs(0, 1));
    rd_if.rd_ready = 1; tick(); rd_if.rd_ready = 0;
    chk("t4_popfill", 32'(fill), 32'd3);
    tick();
    chk("t4_refill", 32'(fill), 32'd4);
    dq.push_back(cs(1, 6)); dq.push_back(cs(2, 4));
    rd_if.rd_ready = 1; tick(2); rd_if.rd_ready = 0;
    chk("t4_fill3", 32'(fill), 32'd3);
    chk("t4_ovf",   32'(ovf), 32'd1);

    // 5: clr flushes and restarts timestamp; nonzero channels re-logged
    clr = 1; tick(); clr = 0;
    chk("t5_fill",  32'(fill), 32'd0);
    chk("t5_ovf",   32'(ovf), 32'd0);
    chk("t5_valid", 32'(rd_if.rd_valid), 32'd0);
    tick();
    chk("t5_relog", 32'(rd_if.rd_data), 32'h03_0000);
    dq.push_back(cs(0, 3)); dq.push_back(cs(1, 6)); dq.push_back(cs(2, 4));
    dq.push_back(cs(3, 8)); dq.push_back(cs(4, 9));
    rd_if.rd_ready = 1; tick(10); rd_if.rd_ready = 0;
    chk("t5_dq", 32'(dq.size()), 32'd0);

    // 6: trigger then burst of changes
`ifdef DBG_TRACE_FREEZE_EN
    exp_fill = DEPTH/2;
`else
    exp_fill = DEPTH;
`endif
    trig = 1; tick(); trig = 0; tick(2);
    set_ch(0, 10); set_ch(1, 11); set_ch(2, 12); set_ch(3, 13); set_ch(4, 14);
    tick(8);
    chk("t6_fill", 32'(fill), 32'(exp_fill));
    chk("t6_frz",  32'(frozen), 32'(exp_fill != DEPTH));
    chk("t6_ovf",  32'(ovf), 32'(exp_fill == DEPTH));
    for (int i = 0; i < exp_fill; i++) dq.push_back(cs(i, 10 + i));
    rd_if.rd_ready = 1; tick(6); rd_if.rd_ready = 0;
    chk("t6_drain", 32'(fill), 32'd0);
    chk("t6_frz2",  32'(frozen), 32'(exp_fill != DEPTH));
    clr = 1; tick(); clr = 0;
    chk("t6_unfrz", 32'(frozen), 32'd0);
    rd_if.rd_ready = 1; tick(8); rd_if.rd_ready = 0;

    // 7: rst mid-operation drops everything, ts restarts
    set_ch(0, 20); tick();
    chk("t7_fill", 32'(fill), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("t7_rfill", 32'(fill), 32'd0);
    chk("t7_rdata", 32'(rd_if.rd_data), 32'd0);
    tick();
    chk("t7_relog", 32'(rd_if.rd_data), 32'h14_0000);
    rd_if.rd_ready = 1; tick(8); rd_if.rd_ready = 0;
    chk("end_fill", 32'(fill), 32'd0);
    chk("end_dq", 32'(dq.size()), 32'd0);

    finish_run();
  end
endmodule
